// File: rtl/block_transfer_sequencer_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer: state
// encodings, addressing-mode encodings and word size.
package block_transfer_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_XFER   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Addressing mode as the {P,U} pair taken straight from the instruction.
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } mode_e;

  localparam int unsigned WORD_BYTES = 4;

  // Size in bytes of the block covered by n registers.
  function automatic logic [31:0] span_bytes(input logic [4:0] n);
    return 32'(n) * WORD_BYTES;
  endfunction

endpackage

// File: rtl/block_transfer_sequencer_lowest_set_bit16.sv
// 16-bit priority encoder: index of the lowest set bit, plus a valid flag
// that is low when no bit is set.
module lowest_set_bit16 (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        valid
);

  // Scan from the top so the last hit (lowest index) wins.
  always_comb begin
    idx   = 4'd0;
    valid = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/block_transfer_sequencer.sv
// MEM-stage sequencer for ARM LDM/STM. Turns one block-transfer request into
// a run of single-word accesses (lowest register at lowest address), returns
// loaded words to the register file and performs base writeback.
//
// state  | meaning
// IDLE   | waiting for start; memory disabled, busy low
// XFER   | one word access per cycle, lowest remaining register first
// FINISH | done pulse and optional base writeback, then back to IDLE
module block_transfer_sequencer
  import block_transfer_sequencer_pkg::*;
#(
  parameter int DM_ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_load,
  input  logic                 p_bit,
  input  logic                 u_bit,
  input  logic                 w_bit,
  input  logic [3:0]           base_reg,
  input  logic [31:0]          base_val,
  input  logic [15:0]          reg_list,
  output logic [3:0]           rf_rd_addr,
  input  logic [31:0]          rf_rd_data,
  output logic                 rf_wr_en,
  output logic [3:0]           rf_wr_addr,
  output logic [31:0]          rf_wr_data,
  output logic [DM_ADDR_W-1:0] dm_addr,
  output logic                 dm_size,
  output logic                 dm_rw,
  output logic                 dm_en,
  output logic [31:0]          dm_di,
  input  logic [31:0]          dm_do,
  output logic                 busy,
  output logic                 done
);

  localparam logic [DM_ADDR_W-1:0] WORD_STEP = DM_ADDR_W'(WORD_BYTES);

  state_e               state_q, state_d;
  logic                 is_load_q, is_load_d;
  logic                 wb_en_q, wb_en_d;
  logic [3:0]           base_reg_q, base_reg_d;
  logic [15:0]          mask_q, mask_d;
  logic [DM_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]          wb_val_q, wb_val_d;

  logic [4:0]           list_cnt;
  logic [31:0]          base_al;
  logic [31:0]          span;
  logic [31:0]          wb_calc;
  logic [DM_ADDR_W-1:0] base_lo;
  logic [DM_ADDR_W-1:0] span_lo;
  logic [DM_ADDR_W-1:0] start_lo;
  logic [3:0]           lsb_idx;
  logic                 lsb_valid;

  lowest_set_bit16 u_lsb (
    .vec   (mask_q),
    .idx   (lsb_idx),
    .valid (lsb_valid)
  );

  // Number of registers in the incoming request.
  always_comb begin
    list_cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      list_cnt = list_cnt + 5'(reg_list[i]);
    end
  end

  // Start address and writeback value for the incoming request. Memory
  // addresses only need the low DM_ADDR_W bits, which wrap naturally; the
  // writeback value keeps the full 32 bits.
  always_comb begin
    base_al = {base_val[31:2], 2'b00};
    span    = span_bytes(list_cnt);
    wb_calc = u_bit ? (base_al + span) : (base_al - span);
    base_lo = DM_ADDR_W'(base_al);
    span_lo = DM_ADDR_W'(span);
    case ({p_bit, u_bit})
      MODE_IA: start_lo = base_lo;
      MODE_IB: start_lo = base_lo + WORD_STEP;
      MODE_DA: start_lo = base_lo - span_lo + WORD_STEP;
      MODE_DB: start_lo = base_lo - span_lo;
      default: start_lo = base_lo;
    endcase
  end

  // Next-state and latched-field update.
  always_comb begin
    state_d    = state_q;
    is_load_d  = is_load_q;
    wb_en_d    = wb_en_q;
    base_reg_d = base_reg_q;
    mask_d     = mask_q;
    addr_d     = addr_q;
    wb_val_d   = wb_val_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_load_d  = is_load;
          // A load that includes Rn keeps the loaded value, so the
          // writeback is dropped up front rather than tracked through XFER.
          wb_en_d    = w_bit & ~(is_load & reg_list[base_reg]);
          base_reg_d = base_reg;
          mask_d     = reg_list;
          addr_d     = start_lo;
          wb_val_d   = wb_calc;
          state_d    = (reg_list == 16'h0000) ? ST_FINISH : ST_XFER;
        end
      end
      ST_XFER: begin
        mask_d = mask_q & ~(16'h0001 << lsb_idx);
        addr_d = addr_q + WORD_STEP;
        if (!lsb_valid || (mask_d == 16'h0000)) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and latched fields; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      is_load_q  <= 1'b0;
      wb_en_q    <= 1'b0;
      base_reg_q <= 4'd0;
      mask_q     <= 16'h0000;
      addr_q     <= '0;
      wb_val_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      is_load_q  <= is_load_d;
      wb_en_q    <= wb_en_d;
      base_reg_q <= base_reg_d;
      mask_q     <= mask_d;
      addr_q     <= addr_d;
      wb_val_q   <= wb_val_d;
    end
  end

  assign dm_size = 1'b1;
  assign busy    = (state_q != ST_IDLE);

  // Memory and register-file drive, decoded from registered state so that
  // reset removes every strobe in the same cycle.
  always_comb begin
    rf_rd_addr = 4'd0;
    rf_wr_en   = 1'b0;
    rf_wr_addr = 4'd0;
    rf_wr_data = 32'h0;
    dm_addr    = '0;
    dm_rw      = 1'b0;
    dm_en      = 1'b0;
    dm_di      = 32'h0;
    done       = 1'b0;
    case (state_q)
      ST_XFER: begin
        dm_addr = addr_q;
        if (is_load_q) begin
          rf_wr_en   = 1'b1;
          rf_wr_addr = lsb_idx;
          rf_wr_data = dm_do;
        end else begin
          rf_rd_addr = lsb_idx;
          dm_di      = rf_rd_data;
          dm_rw      = 1'b1;
          dm_en      = 1'b1;
        end
      end
      ST_FINISH: begin
        done = 1'b1;
        if (wb_en_q) begin
          rf_wr_en   = 1'b1;
          rf_wr_addr = base_reg_q;
          rf_wr_data = wb_val_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_block_transfer_sequencer.sv
module tb_block_transfer_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, is_load, p_bit, u_bit, w_bit;
  logic [3:0]  base_reg;
  logic [31:0] base_val;
  logic [15:0] reg_list;
  logic [3:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        rf_wr_en;
  logic [3:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [7:0]  dm_addr;
  logic        dm_size, dm_rw, dm_en;
  logic [31:0] dm_di, dm_do;
  logic        busy, done;

  always #5 clk = ~clk;

  block_transfer_sequencer #(.DM_ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load),
    .p_bit(p_bit), .u_bit(u_bit), .w_bit(w_bit), .base_reg(base_reg),
    .base_val(base_val), .reg_list(reg_list), .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data), .dm_addr(dm_addr), .dm_size(dm_size),
    .dm_rw(dm_rw), .dm_en(dm_en), .dm_di(dm_di), .dm_do(dm_do),
    .busy(busy), .done(done)
  );

  // Environment: byte memory and register file driven by the DUT.
  logic [7:0]  mem[256];
  logic [31:0] rf[16];
  logic [7:0]  init_mem[256];
  logic [31:0] init_rf[16];
  logic        load_req = 1'b0;
  // Reference copies, updated by the bench's own model.
  logic [7:0]  ref_mem[256];
  logic [31:0] ref_rf[16];

  int checks = 0;
  int errors = 0;

  assign rf_rd_data = rf[rf_rd_addr];
  assign dm_do = {mem[dm_addr], mem[dm_addr + 8'd1], mem[dm_addr + 8'd2], mem[dm_addr + 8'd3]};

  always @(posedge clk) begin
    if (load_req) begin
      mem <= init_mem;
      rf  <= init_rf;
    end else begin
      if (dm_en && dm_rw) begin
        mem[dm_addr]        <= dm_di[31:24];
        mem[dm_addr + 8'd1] <= dm_di[23:16];
        mem[dm_addr + 8'd2] <= dm_di[15:8];
        mem[dm_addr + 8'd3] <= dm_di[7:0];
      end
      if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
    end
  end

  typedef struct {
    logic        ld, p, u, w;
    logic [3:0]  rn;
    logic [31:0] base;
    logic [15:0] list;
    bit          poke;
    logic [7:0]  first;
    logic        wb_en;
    logic [31:0] wb_val;
    int          busy_cyc;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input logic ld, p, u, w, input logic [3:0] rn,
                              input logic [31:0] base, input logic [15:0] list,
                              input bit poke, input logic [7:0] first,
                              input logic wb_en, input logic [31:0] wb_val,
                              input int busy_cyc);
    vec_t v;
    v.ld = ld; v.p = p; v.u = u; v.w = w; v.rn = rn; v.base = base;
    v.list = list; v.poke = poke; v.first = first; v.wb_en = wb_en;
    v.wb_val = wb_val; v.busy_cyc = busy_cyc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
  endfunction

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    return {ref_mem[a], ref_mem[a + 8'd1], ref_mem[a + 8'd2], ref_mem[a + 8'd3]};
  endfunction

  task automatic ref_store(input logic [7:0] a, input logic [31:0] d);
    ref_mem[a]        = d[31:24];
    ref_mem[a + 8'd1] = d[23:16];
    ref_mem[a + 8'd2] = d[15:8];
    ref_mem[a + 8'd3] = d[7:0];
  endtask

  task automatic sync_env();
    init_mem = ref_mem;
    init_rf  = ref_rf;
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
  endtask

  task automatic check_idle(input string name);
    chk({name, ".busy"}, busy, 0);
    chk({name, ".done"}, done, 0);
    chk({name, ".dm_en"}, dm_en, 0);
    chk({name, ".dm_rw"}, dm_rw, 0);
    chk({name, ".dm_size"}, dm_size, 1);
    chk({name, ".dm_addr"}, dm_addr, 0);
    chk({name, ".dm_di"}, dm_di, 0);
    chk({name, ".rf_wr_en"}, rf_wr_en, 0);
    chk({name, ".rf_wr_addr"}, rf_wr_addr, 0);
    chk({name, ".rf_wr_data"}, rf_wr_data, 0);
    chk({name, ".rf_rd_addr"}, rf_rd_addr, 0);
  endtask

  task automatic check_state(input string name);
    int dmem = 0;
    int drf = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) dmem++;
    for (int r = 0; r < 16; r++) if (rf[r] !== ref_rf[r]) drf++;
    chk({name, ".mem_diffs"}, dmem, 0);
    chk({name, ".rf_diffs"}, drf, 0);
  endtask

  // Runs one request from a negedge with the DUT idle. The reference places
  // the n listed registers, in ascending order, in the contiguous block whose
  // lowest word is derived from P/U; writeback is base +/- 4n.
  task automatic run_txn(input logic ld, p, u, w, input logic [3:0] rn,
                         input logic [31:0] base, input logic [15:0] list,
                         input bit poke, input string name,
                         output logic [7:0] obs_first, output logic obs_wb_en,
                         output logic [31:0] obs_wb_val, output int obs_busy);
    int          regs[$];
    int          n;
    int          cyc;
    int          guard;
    logic [31:0] base_al, lowest, wbv, ea;
    logic [7:0]  a8;
    logic        wb_exp;

    obs_first = 8'h00; obs_wb_en = 1'b0; obs_wb_val = 32'h0; obs_busy = 0;
    n = $countones(list);
    for (int r = 0; r < 16; r++) if (list[r]) regs.push_back(r);
    base_al = {base[31:2], 2'b00};
    if (u) lowest = base_al + (p ? 32'd4 : 32'd0);
    else   lowest = base_al - 32'(4 * n) + (p ? 32'd0 : 32'd4);
    wbv    = u ? base_al + 32'(4 * n) : base_al - 32'(4 * n);
    wb_exp = w && !(ld && list[rn]);

    is_load = ld; p_bit = p; u_bit = u; w_bit = w; base_reg = rn;
    base_val = base; reg_list = list; start = 1'b1;
    cyc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      start = poke && (cyc == 1);
      if (cyc == 1) begin
        is_load = 1'($urandom); p_bit = 1'($urandom); u_bit = 1'($urandom);
        w_bit = 1'($urandom); base_reg = 4'($urandom);
        base_val = $urandom; reg_list = 16'($urandom);
      end
      if (busy) obs_busy++;
      ea = lowest + 32'(4 * i);
      a8 = ea[7:0];
      if (i == 0) obs_first = dm_addr;
      chk({name, ".acc_done"}, done, 0);
      chk({name, ".acc_addr"}, dm_addr, a8);
      if (!ld) begin
        chk({name, ".st_en_rw"}, {dm_en, dm_rw, rf_wr_en}, 3'b110);
        chk({name, ".st_rd_addr"}, rf_rd_addr, regs[i]);
        chk({name, ".st_di"}, dm_di, ref_rf[regs[i]]);
        ref_store(a8, ref_rf[regs[i]]);
      end else begin
        chk({name, ".ld_en_rw"}, {dm_en, dm_rw, rf_wr_en}, 3'b001);
        chk({name, ".ld_wr_addr"}, rf_wr_addr, regs[i]);
        chk({name, ".ld_wr_data"}, rf_wr_data, ref_word(a8));
        ref_rf[regs[i]] = ref_word(a8);
      end
    end
    @(negedge clk);
    cyc++;
    start = poke && (cyc == 1);
    if (busy) obs_busy++;
    obs_wb_en  = rf_wr_en;
    obs_wb_val = rf_wr_en ? rf_wr_data : 32'h0;
    chk({name, ".fin_done"}, done, 1);
    chk({name, ".fin_dm_en"}, dm_en, 0);
    chk({name, ".fin_wb_en"}, rf_wr_en, wb_exp);
    if (wb_exp) begin
      chk({name, ".fin_wb_addr"}, rf_wr_addr, rn);
      chk({name, ".fin_wb_data"}, rf_wr_data, wbv);
      ref_rf[rn] = wbv;
    end
    @(negedge clk);
    start = 1'b0;
    chk({name, ".after_busy"}, busy, 0);
    chk({name, ".after_done"}, done, 0);
    chk({name, ".after_dm_en"}, dm_en, 0);
    guard = 0;
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s.hang: busy still 1 after 50 extra cycles, required 0", name);
    end
    check_state(name);
  endtask

  initial begin
    logic [7:0]  of;
    logic        ow;
    logic [31:0] owv;
    int          ob;
    bit          saw_done;
    logic [15:0] rl;

    reset = 1'b1; start = 1'b0; is_load = 1'b0; p_bit = 1'b0; u_bit = 1'b0;
    w_bit = 1'b0; base_reg = 4'd0; base_val = 32'h0; reg_list = 16'h0;
    #1;
    check_idle("reset");

    for (int r = 0; r < 16; r++) ref_rf[r] = 32'h11111111 * r;
    for (int a = 0; a < 256; a++) ref_mem[a] = 8'(a) ^ 8'h5A;
    ref_store(8'h38, 32'hDEADBEEF);
    ref_store(8'h3C, 32'h01020304);
    sync_env();
    @(negedge clk) reset = 1'b0;
    check_idle("post_reset");

    //                ld p  u  w  rn     base           list     poke first  wb  wb_val          busy
    vecs[0] = mk(0, 0, 1, 1, 4'd5,  32'h0000_0010, 16'h000E, 0, 8'h10, 1, 32'h0000_001C, 4);
    vecs[1] = mk(1, 1, 0, 0, 4'd6,  32'h0000_0040, 16'h0011, 0, 8'h38, 0, 32'h0,         3);
    vecs[2] = mk(0, 0, 1, 1, 4'd7,  32'h0000_1237, 16'h0000, 0, 8'h00, 1, 32'h0000_1234, 1);
    vecs[3] = mk(1, 0, 1, 1, 4'd8,  32'h0000_0020, 16'h0104, 0, 8'h20, 0, 32'h0,         3);
    vecs[4] = mk(0, 1, 1, 1, 4'd9,  32'h0000_00F8, 16'h0007, 1, 8'hFC, 1, 32'h0000_0104, 4);
    vecs[5] = mk(0, 0, 0, 1, 4'd2,  32'h0000_0080, 16'h8001, 0, 8'h7C, 1, 32'h0000_0078, 3);
    vecs[6] = mk(1, 1, 0, 1, 4'd3,  32'h0000_0003, 16'h0006, 0, 8'hF8, 1, 32'hFFFF_FFF8, 3);
    vecs[7] = mk(0, 0, 1, 1, 4'd10, 32'h1234_5678, 16'h0001, 0, 8'h78, 1, 32'h1234_567C, 2);

    for (int t = 0; t < 8; t++) begin
      run_txn(vecs[t].ld, vecs[t].p, vecs[t].u, vecs[t].w, vecs[t].rn,
              vecs[t].base, vecs[t].list, vecs[t].poke,
              $sformatf("vec%0d", t), of, ow, owv, ob);
      chk($sformatf("vec%0d.first_addr", t), of, vecs[t].first);
      chk($sformatf("vec%0d.wb_en", t), ow, vecs[t].wb_en);
      chk($sformatf("vec%0d.wb_val", t), owv, vecs[t].wb_val);
      chk($sformatf("vec%0d.busy_cycles", t), ob, vecs[t].busy_cyc);
    end

    chk("stm_ia.word10", mem_word(8'h10), 32'h11111111);
    chk("stm_ia.word14", mem_word(8'h14), 32'h22222222);
    chk("stm_ia.word18", mem_word(8'h18), 32'h33333333);
    chk("stm_ia.rn_wb", rf[5], 32'h0000001C);
    chk("ldm_db.r0", rf[0], 32'hDEADBEEF);
    chk("ldm_db.r4", rf[4], 32'h01020304);
    chk("empty.rn_wb", rf[7], 32'h00001234);
    chk("ldm_rn.r8", rf[8], 32'h7E7F7C7D);

    // Reset during the second access of a four-register STM.
    is_load = 1'b0; p_bit = 1'b0; u_bit = 1'b1; w_bit = 1'b1; base_reg = 4'd11;
    base_val = 32'h50; reg_list = 16'h000F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst.acc1_addr", dm_addr, 8'h50);
    chk("rst.acc1_en", dm_en, 1);
    @(negedge clk);
    chk("rst.acc2_addr", dm_addr, 8'h54);
    reset = 1'b1;
    #1;
    check_idle("rst.mid");
    ref_store(8'h50, ref_rf[0]);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("rst.no_done", saw_done, 0);
    check_state("rst");
    run_txn(0, 0, 1, 1, 4'd11, 32'h50, 16'h000F, 0, "rst.again", of, ow, owv, ob);
    chk("rst.again.first_addr", of, 8'h50);
    chk("rst.again.wb_val", owv, 32'h60);

    for (int t = 0; t < 40; t++) begin
      rl = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      run_txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              4'($urandom), $urandom, rl, ($urandom_range(0, 3) == 0),
              $sformatf("rnd%0d", t), of, ow, owv, ob);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
